// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer and the CRC-32 helper.
package gmii_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StSfd,
      StData,
      StPad,
      StFcs,
      StIfg
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE        = 8'h55;
   localparam logic [7:0]  SFD_BYTE             = 8'hD5;
   localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

   localparam int unsigned BYTE_CNT_W = 11;
   typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB of data first).
module crc32_d8
   import gmii_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = (c >> 1) ^ CRC32_POLY_REFLECTED;
         end else begin
            c = c >> 1;
         end
      end
      crc_out = c;
   end

endmodule

// File: rtl/gmii_tx_framer.sv
// MAC transmit framer: wraps a client byte stream with preamble, SFD, zero pad,
// CRC-32 FCS and inter-frame gap, driving registered GMII MAC-side outputs.
module gmii_tx_framer
   import gmii_pkg::*;
#(
   parameter int unsigned PREAMBLE_BYTES  = 7,
   parameter int unsigned MIN_FRAME_BYTES = 60,
   parameter int unsigned IFG_BYTES       = 12
) (
   input  logic       clock_125MHz,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   input  logic       tx_error,
   output logic       tx_ready,
   output logic [7:0] mac_txd,
   output logic       mac_tx_en,
   output logic       mac_tx_er,
   output logic       tx_busy,
   output logic       frame_done,
   output logic       frame_aborted
);

   tx_state_e   state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   byte_cnt_t   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
   logic [31:0] crc_q, crc_d, crc_next, crc_inv;
   logic [7:0]  crc_data;
   logic        pad_needed;

   logic [7:0]  txd_q, txd_d;
   logic        en_q, en_d, er_q, er_d, done_q, done_d, abort_q, abort_d;

   assign tx_ready      = (state_q == StSfd) || (state_q == StData);
   assign tx_busy       = (state_q != StIdle);
   assign mac_txd       = txd_q;
   assign mac_tx_en     = en_q;
   assign mac_tx_er     = er_q;
   assign frame_done    = done_q;
   assign frame_aborted = abort_q;

   assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + byte_cnt_t'(1);
   assign pad_needed   = byte_cnt_inc < byte_cnt_t'(MIN_FRAME_BYTES);
   assign crc_data     = (state_q == StPad) ? 8'h00 : tx_data;
   assign crc_inv      = ~crc_q;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (crc_data),
      .crc_out (crc_next)
   );

   // Every state decides what appears on the wire in the following cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      byte_cnt_d = byte_cnt_q;
      crc_d      = crc_q;
      txd_d      = 8'h00;
      en_d       = 1'b0;
      er_d       = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (tx_valid) begin
               state_d = StPreamble;
               cnt_d   = 8'd1;
               txd_d   = PREAMBLE_BYTE;
               en_d    = 1'b1;
            end
         end
         StPreamble: begin
            en_d = 1'b1;
            if (cnt_q >= 8'(PREAMBLE_BYTES)) begin
               state_d = StSfd;
               cnt_d   = 8'd0;
               txd_d   = SFD_BYTE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               txd_d = PREAMBLE_BYTE;
            end
         end
         StSfd, StData: begin
            en_d = 1'b1;
            if (tx_valid) begin
               txd_d      = tx_data;
               er_d       = tx_error;
               crc_d      = crc_next;
               byte_cnt_d = byte_cnt_inc;
               state_d    = StData;
               if (tx_last) begin
                  state_d = pad_needed ? StPad : StFcs;
                  cnt_d   = 8'd0;
               end
            end else begin
               // Underrun: poison the frame and skip the FCS.
               er_d    = 1'b1;
               abort_d = 1'b1;
               state_d = StIfg;
               cnt_d   = 8'd0;
            end
         end
         StPad: begin
            en_d       = 1'b1;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
            if (!pad_needed) begin
               state_d = StFcs;
               cnt_d   = 8'd0;
            end
         end
         StFcs: begin
            en_d  = 1'b1;
            txd_d = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q[1:0] == 2'd3) begin
               done_d  = 1'b1;
               state_d = StIfg;
               cnt_d   = 8'd0;
            end
         end
         StIfg: begin
            if (cnt_q >= 8'(IFG_BYTES)) begin
               crc_d      = CRC32_INIT;
               byte_cnt_d = '0;
               // Launch the next preamble straight from the last gap cycle.
               if (tx_valid) begin
                  state_d = StPreamble;
                  cnt_d   = 8'd1;
                  txd_d   = PREAMBLE_BYTE;
                  en_d    = 1'b1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = 8'd0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clock_125MHz or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         byte_cnt_q <= '0;
         crc_q      <= CRC32_INIT;
         txd_q      <= 8'h00;
         en_q       <= 1'b0;
         er_q       <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_cnt_q <= byte_cnt_d;
         crc_q      <= crc_d;
         txd_q      <= txd_d;
         en_q       <= en_d;
         er_q       <= er_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: one instance with MIN_FRAME_BYTES=9, one with defaults.
module tb_gmii_tx_framer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_error = 1'b0;

   logic       a_rdy, a_en, a_er, a_busy, a_done, a_abort;
   logic       b_rdy, b_en, b_er, b_busy, b_done, b_abort;
   logic [7:0] a_txd, b_txd;

   logic       sel = 1'b0;
   logic       s_rdy, s_en, s_er, s_busy, s_done, s_abort;
   logic [7:0] s_txd;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0] pl[$];
   logic [7:0] mdl[$];
   logic [7:0] q_txd[$];
   bit         q_en[$], q_er[$], q_done[$], q_abort[$], q_rdy[$];

   int          d1, p2;
   logic [31:0] fcs;

   always #4 clk = ~clk;

   gmii_tx_framer #(.MIN_FRAME_BYTES(9)) u_a (
      .clock_125MHz  (clk),
      .reset         (rst_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_last       (tx_last),
      .tx_error      (tx_error),
      .tx_ready      (a_rdy),
      .mac_txd       (a_txd),
      .mac_tx_en     (a_en),
      .mac_tx_er     (a_er),
      .tx_busy       (a_busy),
      .frame_done    (a_done),
      .frame_aborted (a_abort)
   );

   gmii_tx_framer u_b (
      .clock_125MHz  (clk),
      .reset         (rst_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_last       (tx_last),
      .tx_error      (tx_error),
      .tx_ready      (b_rdy),
      .mac_txd       (b_txd),
      .mac_tx_en     (b_en),
      .mac_tx_er     (b_er),
      .tx_busy       (b_busy),
      .frame_done    (b_done),
      .frame_aborted (b_abort)
   );

   assign s_rdy   = sel ? b_rdy   : a_rdy;
   assign s_en    = sel ? b_en    : a_en;
   assign s_er    = sel ? b_er    : a_er;
   assign s_busy  = sel ? b_busy  : a_busy;
   assign s_done  = sel ? b_done  : a_done;
   assign s_abort = sel ? b_abort : a_abort;
   assign s_txd   = sel ? b_txd   : a_txd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // MSB-first CRC-32 over bit-reversed bytes; result is the FCS word, LSB sent first.
   function automatic logic [31:0] fcs_ref();
      logic [31:0] r;
      logic [7:0]  b;
      r = 32'hFFFFFFFF;
      foreach (mdl[i]) begin
         b = rev8(mdl[i]);
         for (int k = 7; k >= 0; k--) begin
            if (r[31] ^ b[k]) r = (r << 1) ^ 32'h04C11DB7;
            else              r = r << 1;
         end
      end
      return ~rev32(r);
   endfunction

   // which: 0 en, 1 er, 2 done, 3 ready
   function automatic int ones(input int which, input int lo, input int hi);
      int n;
      n = 0;
      for (int i = lo; i <= hi; i++) begin
         case (which)
            0:       n += int'(q_en[i]);
            1:       n += int'(q_er[i]);
            2:       n += int'(q_done[i]);
            default: n += int'(q_rdy[i]);
         endcase
      end
      return n;
   endfunction

   task automatic drive(input int idx, input int err_idx);
      tx_valid = 1'b1;
      tx_data  = pl[idx];
      tx_last  = (idx == pl.size() - 1);
      tx_error = (idx == err_idx);
   endtask

   // Called just after a clock edge; entry i of the capture queues is wire cycle i+1.
   task automatic run(input int nframes, input int err_idx, input int drop_at, input int cycles);
      int idx, left;
      bit dropped, r;
      q_txd.delete(); q_en.delete(); q_er.delete();
      q_done.delete(); q_abort.delete(); q_rdy.delete();
      idx = 0; left = nframes; dropped = 0;
      drive(idx, err_idx);
      for (int c = 0; c < cycles; c++) begin
         r = s_rdy;
         @(posedge clk); #1;
         if (r && tx_valid) begin
            idx++;
            if (idx == pl.size()) begin
               idx = 0;
               left--;
            end
         end
         q_txd.push_back(s_txd);
         q_en.push_back(s_en);
         q_er.push_back(s_er);
         q_done.push_back(s_done);
         q_abort.push_back(s_abort);
         q_rdy.push_back(s_rdy);
         if (drop_at >= 0 && idx == drop_at) dropped = 1;
         if (left > 0 && !dropped) drive(idx, err_idx);
         else begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            tx_error = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_error = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_a_en", a_en, 1'b0);
      chk("rst_a_txd", a_txd, 8'h00);
      chk("rst_a_busy", a_busy, 1'b0);
      chk("rst_a_rdy", a_rdy, 1'b0);
      chk("rst_b_er", b_er, 1'b0);
      chk("rst_b_done", b_done, 1'b0);
      chk("rst_b_abort", b_abort, 1'b0);

      // "123456789" with MIN_FRAME_BYTES=9: no pad, FCS 26 39 F4 CB
      sel = 1'b0;
      pl.delete();
      for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
      run(1, -1, -1, 40);
      for (int i = 0; i < 7; i++) chk("t1_pre", q_txd[i], 8'h55);
      chk("t1_sfd", q_txd[7], 8'hD5);
      for (int i = 0; i < 9; i++) chk("t1_data", q_txd[8+i], pl[i]);
      chk("t1_fcs0", q_txd[17], 8'h26);
      chk("t1_fcs1", q_txd[18], 8'h39);
      chk("t1_fcs2", q_txd[19], 8'hF4);
      chk("t1_fcs3", q_txd[20], 8'hCB);
      chk("t1_done_at", q_done[20], 1'b1);
      chk("t1_done_cnt", ones(2, 0, 39), 1);
      chk("t1_en_cnt", ones(0, 0, 20), 21);
      chk("t1_ifg_en", ones(0, 21, 32), 0);
      chk("t1_er_cnt", ones(1, 0, 39), 0);
      chk("t1_rdy_pre", q_rdy[6], 1'b0);
      chk("t1_rdy_sfd", q_rdy[7], 1'b1);
      chk("t1_rdy_data", q_rdy[15], 1'b1);
      chk("t1_rdy_fcs", q_rdy[16], 1'b0);

      // Default params, single byte 0xAB: 59 pad bytes, 72 enabled cycles
      do_reset();
      sel = 1'b1;
      pl.delete();
      pl.push_back(8'hAB);
      run(1, -1, -1, 100);
      mdl.delete();
      mdl.push_back(8'hAB);
      for (int i = 0; i < 59; i++) mdl.push_back(8'h00);
      fcs = fcs_ref();
      chk("t2_data", q_txd[8], 8'hAB);
      chk("t2_pad_first", q_txd[9], 8'h00);
      chk("t2_pad_last", q_txd[67], 8'h00);
      for (int i = 0; i < 4; i++) chk("t2_fcs", q_txd[68+i], fcs[8*i +: 8]);
      chk("t2_en_cnt", ones(0, 0, 99), 72);
      chk("t2_en_last", q_en[71], 1'b1);
      chk("t2_en_after", q_en[72], 1'b0);
      chk("t2_done_at", q_done[71], 1'b1);

      // Underrun after 20 accepted bytes
      do_reset();
      pl.delete();
      for (int i = 0; i < 40; i++) pl.push_back(8'(i + 1));
      run(1, -1, 20, 45);
      chk("t3_last_data", q_txd[27], 8'h14);
      chk("t3_last_er", q_er[27], 1'b0);
      chk("t3_ab_txd", q_txd[28], 8'h00);
      chk("t3_ab_en", q_en[28], 1'b1);
      chk("t3_ab_er", q_er[28], 1'b1);
      chk("t3_ab_pulse", q_abort[28], 1'b1);
      chk("t3_ab_once", q_abort[29], 1'b0);
      chk("t3_ifg_en", ones(0, 29, 40), 0);
      chk("t3_no_done", ones(2, 0, 44), 0);

      // Two back-to-back 60-byte frames with tx_valid held high
      do_reset();
      pl.delete();
      for (int i = 0; i < 60; i++) pl.push_back(8'h10 + 8'(i));
      run(2, -1, -1, 200);
      d1 = -1;
      p2 = -1;
      for (int i = 0; i < 200; i++) if (d1 < 0 && q_done[i]) d1 = i;
      if (d1 >= 0) for (int i = d1 + 1; i < 200; i++) if (p2 < 0 && q_en[i]) p2 = i;
      chk("t4_done1_at", d1, 71);
      chk("t4_gap", p2 - d1, 13);
      if (d1 >= 0 && p2 > d1) begin
         chk("t4_pre2", q_txd[p2], 8'h55);
         chk("t4_gap_rdy", ones(3, d1, p2), 0);
      end
      mdl = pl;
      fcs = fcs_ref();
      for (int i = 0; i < 4; i++) chk("t4_fcs2", q_txd[152+i], fcs[8*i +: 8]);
      chk("t4_done2", q_done[155], 1'b1);

      // tx_error on the fifth byte of a 64-byte frame
      do_reset();
      pl.delete();
      for (int i = 0; i < 64; i++) pl.push_back(8'(3 * i + 1));
      run(1, 4, -1, 90);
      mdl = pl;
      fcs = fcs_ref();
      chk("t5_er_at", q_er[12], 1'b1);
      chk("t5_er_cnt", ones(1, 0, 89), 1);
      chk("t5_err_byte", q_txd[12], 8'h0D);
      for (int i = 0; i < 4; i++) chk("t5_fcs", q_txd[72+i], fcs[8*i +: 8]);
      chk("t5_done", q_done[75], 1'b1);

      // Asynchronous reset in the middle of DATA, then a fresh padded frame
      do_reset();
      pl.delete();
      for (int i = 0; i < 30; i++) pl.push_back(8'hA0 + 8'(i));
      run(1, -1, -1, 15);
      chk("t6_mid_en", s_en, 1'b1);
      chk("t6_mid_rdy", s_rdy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_en", s_en, 1'b0);
      chk("t6_rst_rdy", s_rdy, 1'b0);
      chk("t6_rst_busy", s_busy, 1'b0);
      tx_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      pl.delete();
      for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
      run(1, -1, -1, 90);
      mdl = pl;
      for (int i = 0; i < 51; i++) mdl.push_back(8'h00);
      fcs = fcs_ref();
      chk("t6_sfd", q_txd[7], 8'hD5);
      for (int i = 0; i < 4; i++) chk("t6_fcs", q_txd[68+i], fcs[8*i +: 8]);
      chk("t6_done", q_done[71], 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
